// File: rtl/tm_pkg.sv
// Shared definitions for the Turing-machine step sequencer and its period counter.
package tm_pkg;

  localparam int TM_WIDTH = 16;
  localparam int TM_CW    = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_STEP = 3'd2,
    ST_ACK  = 3'd3,
    ST_HALT = 3'd4
  } step_state_t;

endpackage

// File: rtl/threshold_counter.sv
// Period counter placed beside step_controller: counts while enabled, flags the threshold, clears when disabled.
module threshold_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             en,
  input  logic [WIDTH-1:0] max,
  output logic             reach_max
);

  logic [WIDTH-1:0] cnt;

  // Count up to max, wrap to zero after reaching it, and hold at zero whenever disabled.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt < max) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  assign reach_max = en && (cnt >= max);

endmodule

// File: rtl/step_controller.sv
// Run/single-step sequencer: turns counter threshold pulses into acknowledged one-cycle step strobes.
module step_controller
  import tm_pkg::*;
#(
  parameter int WIDTH = TM_WIDTH,
  parameter int CW    = TM_CW
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             run,
  input  logic             single,
  input  logic             clr,
  input  logic [WIDTH-1:0] period,
  input  logic             reach_max,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_max,
  output logic             step,
  input  logic             step_ack,
  input  logic             halted,
  output logic             busy,
  output logic [2:0]       state,
  output logic [CW-1:0]    step_count
);

  step_state_t cur_state;
  step_state_t next_state;

  // State register; reset drops any step in flight and returns straight to IDLE.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next-state selection; halted always wins, and HALT is left only through clr.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_IDLE: begin
        if (halted)      next_state = ST_HALT;
        else if (single) next_state = ST_STEP;
        else if (run)    next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (halted)         next_state = ST_HALT;
        else if (!run)      next_state = ST_IDLE;
        else if (reach_max) next_state = ST_STEP;
      end
      ST_STEP: next_state = ST_ACK;
      ST_ACK: begin
        if (step_ack) begin
          if (halted)   next_state = ST_HALT;
          else if (run) next_state = ST_WAIT;
          else          next_state = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (clr) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded purely from the current state so they stay glitch-free relative to the register.
  always_comb begin
    cnt_en = 1'b0;
    step   = 1'b0;
    busy   = 1'b0;
    case (cur_state)
      ST_WAIT: begin
        cnt_en = 1'b1;
        busy   = 1'b1;
      end
      ST_STEP: begin
        step = 1'b1;
        busy = 1'b1;
      end
      ST_ACK:  busy = 1'b1;
      default: ;
    endcase
  end

  assign state = cur_state;

  // Capture the period only when WAIT is being entered, so mid-wait changes wait for the next period.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      cnt_max <= '0;
    end else if ((next_state == ST_WAIT) && (cur_state != ST_WAIT)) begin
      cnt_max <= period;
    end
  end

  // Count acknowledged steps, saturating at all-ones; clr overrides a same-cycle increment.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      step_count <= '0;
    end else if (clr) begin
      step_count <= '0;
    end else if ((cur_state == ST_ACK) && step_ack && (step_count != {CW{1'b1}})) begin
      step_count <= step_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller with the period counter and an acking core model alongside.
module tb_step_controller;

  logic        clk;
  logic        Rst;
  logic        run;
  logic        single;
  logic        clr;
  logic [15:0] period;
  logic        reach_max;
  logic        cnt_en;
  logic [15:0] cnt_max;
  logic        step;
  logic        step_ack;
  logic        halted;
  logic        busy;
  logic [2:0]  state;
  logic [31:0] step_count;

  logic        sat_single;
  logic        sat_clr;
  logic        sat_ack;
  logic        sat_cnt_en;
  logic [15:0] sat_cnt_max;
  logic        sat_step;
  logic        sat_busy;
  logic [2:0]  sat_state;
  logic [3:0]  sat_count;

  int  total;
  int  bad;
  int  ack_delay;
  bit  auto_ack;
  int  ack_cnt;

  step_controller #(.WIDTH(16), .CW(32)) u_dut (
    .clk(clk), .Rst(Rst), .run(run), .single(single), .clr(clr), .period(period),
    .reach_max(reach_max), .cnt_en(cnt_en), .cnt_max(cnt_max), .step(step),
    .step_ack(step_ack), .halted(halted), .busy(busy), .state(state), .step_count(step_count)
  );

  threshold_counter #(.WIDTH(16)) u_cnt (
    .clk(clk), .Rst(Rst), .en(cnt_en), .max(cnt_max), .reach_max(reach_max)
  );

  step_controller #(.WIDTH(16), .CW(4)) u_sat (
    .clk(clk), .Rst(Rst), .run(1'b0), .single(sat_single), .clr(sat_clr), .period(16'd0),
    .reach_max(1'b0), .cnt_en(sat_cnt_en), .cnt_max(sat_cnt_max), .step(sat_step),
    .step_ack(sat_ack), .halted(1'b0), .busy(sat_busy), .state(sat_state), .step_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: raises step_ack for one cycle, ack_delay cycles after it sees a step strobe.
  always @(posedge clk or posedge Rst) begin
    if (Rst) begin
      step_ack <= 1'b0;
      ack_cnt  <= 0;
    end else if (step && auto_ack) begin
      if (ack_delay <= 1) begin
        step_ack <= 1'b1;
        ack_cnt  <= 0;
      end else begin
        step_ack <= 1'b0;
        ack_cnt  <= ack_delay - 1;
      end
    end else if (ack_cnt > 0) begin
      ack_cnt  <= ack_cnt - 1;
      step_ack <= (ack_cnt == 1);
    end else begin
      step_ack <= 1'b0;
    end
  end

  // Watchdog so the run always ends even if something wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_idle(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state == 3'd0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL %s_idle: got state %0d want 0 within 20 cycles", name, state);
    end
  endtask

  task automatic test_reset();
    int steps_seen;
    run = 0; single = 0; clr = 0; period = 16'd0; halted = 0;
    auto_ack = 1; ack_delay = 1;
    sat_single = 0; sat_clr = 0; sat_ack = 0;
    Rst = 1;
    tick(); tick();
    Rst = 0;
    total++; if (state !== 3'd0)       begin bad++; $display("[TB] FAIL rst_state: got %0d want 0", state); end
    total++; if (cnt_en !== 1'b0)      begin bad++; $display("[TB] FAIL rst_cnt_en: got %0b want 0", cnt_en); end
    total++; if (cnt_max !== 16'd0)    begin bad++; $display("[TB] FAIL rst_cnt_max: got %0d want 0", cnt_max); end
    total++; if (step !== 1'b0)        begin bad++; $display("[TB] FAIL rst_step: got %0b want 0", step); end
    total++; if (busy !== 1'b0)        begin bad++; $display("[TB] FAIL rst_busy: got %0b want 0", busy); end
    total++; if (step_count !== 32'd0) begin bad++; $display("[TB] FAIL rst_count: got %0d want 0", step_count); end
    total++; if ({sat_step, sat_cnt_en, sat_cnt_max} !== 18'd0)
      begin bad++; $display("[TB] FAIL rst_sat_outs: got %0h want 0", {sat_step, sat_cnt_en, sat_cnt_max}); end

    // one acknowledged single step so the count is nonzero before the mid-ACK reset
    single = 1; tick(); single = 0;
    tick(); tick();
    total++; if (step_count !== 32'd1) begin bad++; $display("[TB] FAIL rst_pre_count: got %0d want 1", step_count); end

    auto_ack = 0;
    single = 1; tick(); single = 0;
    total++; if (step !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_step: got %0b want 1", step); end
    tick();
    total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL rst_pre_ack: got %0d want 3", state); end
    #2 Rst = 1;
    #1;
    total++; if (state !== 3'd0)       begin bad++; $display("[TB] FAIL rst_mid_state: got %0d want 0", state); end
    total++; if (step !== 1'b0)        begin bad++; $display("[TB] FAIL rst_mid_step: got %0b want 0", step); end
    total++; if (cnt_en !== 1'b0)      begin bad++; $display("[TB] FAIL rst_mid_cnt_en: got %0b want 0", cnt_en); end
    total++; if (step_count !== 32'd0) begin bad++; $display("[TB] FAIL rst_mid_count: got %0d want 0", step_count); end
    tick();
    Rst = 0;
    auto_ack = 1;
    steps_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (step) steps_seen++;
    end
    total++; if (steps_seen !== 0) begin bad++; $display("[TB] FAIL rst_no_step: got %0d steps want 0", steps_seen); end
  endtask

  task automatic test_run();
    int  cyc;
    int  n;
    int  at[3];
    bit  started;
    bit  checked;
    period = 16'd3; ack_delay = 1; auto_ack = 1;
    run = 1; started = 0; checked = 0; cyc = 0; n = 0;
    at[0] = -1; at[1] = -1; at[2] = -1;
    // cycle numbering starts at the first WAIT cycle
    for (int i = 0; i < 80; i++) begin
      tick();
      if (!started && state == 3'd1) begin
        started = 1; cyc = 0;
        total++; if (cnt_max !== 16'd3) begin bad++; $display("[TB] FAIL run_cnt_max: got %0d want 3", cnt_max); end
      end else if (started) begin
        cyc++;
      end
      if (started && step && n < 3) begin at[n] = cyc; n++; end
      if (started && cyc == 18) begin
        checked = 1;
        total++; if (step_count !== 32'd3) begin bad++; $display("[TB] FAIL run_count: got %0d want 3", step_count); end
        break;
      end
    end
    total++; if (!checked) begin bad++; $display("[TB] FAIL run_timeout: got no completion want cycle 18"); end
    total++; if (at[0] !== 4)  begin bad++; $display("[TB] FAIL run_step0: got %0d want 4", at[0]); end
    total++; if (at[1] !== 10) begin bad++; $display("[TB] FAIL run_step1: got %0d want 10", at[1]); end
    total++; if (at[2] !== 16) begin bad++; $display("[TB] FAIL run_step2: got %0d want 16", at[2]); end
    run = 0;
    settle_idle("run");
  endtask

  task automatic test_zero_period();
    int  cyc;
    int  n;
    int  at[3];
    bit  started;
    clr = 1; tick(); clr = 0;
    period = 16'd0; ack_delay = 1; auto_ack = 1;
    run = 1; started = 0; cyc = 0; n = 0;
    at[0] = -1; at[1] = -1; at[2] = -1;
    for (int i = 0; i < 40 && n < 3; i++) begin
      tick();
      if (!started && state == 3'd1) begin
        started = 1; cyc = 0;
        total++; if (cnt_max !== 16'd0) begin bad++; $display("[TB] FAIL zero_cnt_max: got %0d want 0", cnt_max); end
      end else if (started) begin
        cyc++;
      end
      if (started && step) begin at[n] = cyc; n++; end
    end
    total++; if (at[0] !== 1) begin bad++; $display("[TB] FAIL zero_step0: got %0d want 1", at[0]); end
    total++; if (at[1] !== 4) begin bad++; $display("[TB] FAIL zero_step1: got %0d want 4", at[1]); end
    total++; if (at[2] !== 7) begin bad++; $display("[TB] FAIL zero_step2: got %0d want 7", at[2]); end
    run = 0;
    settle_idle("zero");
  endtask

  task automatic test_single();
    int n;
    int at;
    clr = 1; tick(); clr = 0;
    run = 0; ack_delay = 1; auto_ack = 1;
    n = 0; at = -1;
    for (int t = 0; t <= 12; t++) begin
      if (step) begin n++; at = t; end
      if (t == 8) begin
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL single_idle: got %0d want 0", state); end
      end
      single = (t == 5) || (t == 7);
      tick();
    end
    single = 0;
    total++; if (n !== 1)   begin bad++; $display("[TB] FAIL single_count_steps: got %0d want 1", n); end
    total++; if (at !== 6)  begin bad++; $display("[TB] FAIL single_step_cycle: got %0d want 6", at); end
    total++; if (step_count !== 32'd1) begin bad++; $display("[TB] FAIL single_count: got %0d want 1", step_count); end
  endtask

  task automatic test_halt();
    int  n;
    int  extra;
    clr = 1; tick(); clr = 0;
    period = 16'd2; ack_delay = 1; auto_ack = 1;
    run = 1; n = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (step) begin
        n++;
        if (n == 3) begin halted = 1; break; end
      end
    end
    total++; if (n !== 3) begin bad++; $display("[TB] FAIL halt_third: got %0d steps want 3", n); end
    tick(); tick();
    total++; if (state !== 3'd4)       begin bad++; $display("[TB] FAIL halt_state: got %0d want 4", state); end
    total++; if (busy !== 1'b0)        begin bad++; $display("[TB] FAIL halt_busy: got %0b want 0", busy); end
    total++; if (cnt_en !== 1'b0)      begin bad++; $display("[TB] FAIL halt_cnt_en: got %0b want 0", cnt_en); end
    total++; if (step_count !== 32'd3) begin bad++; $display("[TB] FAIL halt_count: got %0d want 3", step_count); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      single = (i == 3);
      tick();
      if (step) extra++;
    end
    single = 0;
    total++; if (extra !== 0)     begin bad++; $display("[TB] FAIL halt_no_step: got %0d steps want 0", extra); end
    total++; if (state !== 3'd4)  begin bad++; $display("[TB] FAIL halt_hold: got %0d want 4", state); end
    clr = 1; halted = 0;
    tick();
    clr = 0;
    total++; if (state !== 3'd0)       begin bad++; $display("[TB] FAIL halt_clr_state: got %0d want 0", state); end
    total++; if (step_count !== 32'd0) begin bad++; $display("[TB] FAIL halt_clr_count: got %0d want 0", step_count); end
    run = 0;
    settle_idle("halt");
  endtask

  task automatic test_abort();
    int  n;
    bit  entered;
    period = 16'd100; auto_ack = 1; ack_delay = 1;
    run = 1; entered = 0; n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state == 3'd1) begin entered = 1; break; end
    end
    total++; if (!entered)          begin bad++; $display("[TB] FAIL abort_enter: got state %0d want 1", state); end
    total++; if (cnt_max !== 16'd100) begin bad++; $display("[TB] FAIL abort_cnt_max: got %0d want 100", cnt_max); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (step) n++;
    end
    run = 0;
    tick();
    total++; if (state !== 3'd0)  begin bad++; $display("[TB] FAIL abort_state: got %0d want 0", state); end
    total++; if (cnt_en !== 1'b0) begin bad++; $display("[TB] FAIL abort_cnt_en: got %0b want 0", cnt_en); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (step) n++;
    end
    total++; if (n !== 0) begin bad++; $display("[TB] FAIL abort_no_step: got %0d steps want 0", n); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) begin
      sat_single = 1; tick(); sat_single = 0;
      tick();
      if (i == 0) begin
        total++; if (sat_busy !== 1'b1) begin bad++; $display("[TB] FAIL sat_busy_ack: got %0b want 1", sat_busy); end
      end
      sat_ack = 1; tick(); sat_ack = 0;
      if (i == 14) begin
        total++; if (sat_count !== 4'd15) begin bad++; $display("[TB] FAIL sat_count15: got %0d want 15", sat_count); end
      end
    end
    total++; if (sat_count !== 4'd15) begin bad++; $display("[TB] FAIL sat_hold: got %0d want 15", sat_count); end
    sat_single = 1; tick(); sat_single = 0;
    tick();
    sat_ack = 1; sat_clr = 1;
    tick();
    sat_ack = 0; sat_clr = 0;
    total++; if (sat_count !== 4'd0) begin bad++; $display("[TB] FAIL sat_clr_wins: got %0d want 0", sat_count); end
    total++; if (sat_state !== 3'd0) begin bad++; $display("[TB] FAIL sat_state: got %0d want 0", sat_state); end
  endtask

  // Run each scenario in order, then report.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_run();
    test_zero_period();
    test_single();
    test_halt();
    test_abort();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
